// File: rtl/register_alias_table.sv
// Register alias table: speculative map for Rename, retirement map from commit, flush recovery.
// Optional feature macro RAT_ZERO_REG_EN hardwires areg 0 to preg 0.
module register_alias_table #(
    parameter int RENAME_WIDTH = 2,
    parameter int COMMIT_WIDTH = 2,
    parameter int NUM_AREGS    = 32,
    parameter int NUM_PREGS    = 64,
    localparam int AW = $clog2(NUM_AREGS),
    localparam int PW = $clog2(NUM_PREGS)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [RENAME_WIDTH-1:0][1:0][AW-1:0]   rd_areg,
    output logic [RENAME_WIDTH-1:0][1:0][PW-1:0]   rd_preg,
    input  logic [RENAME_WIDTH-1:0]                wr_en,
    input  logic [RENAME_WIDTH-1:0][AW-1:0]        wr_areg,
    input  logic [RENAME_WIDTH-1:0][PW-1:0]        wr_preg,
    output logic [RENAME_WIDTH-1:0][PW-1:0]        old_preg,
    input  logic [COMMIT_WIDTH-1:0]                commit_en,
    input  logic [COMMIT_WIDTH-1:0][AW-1:0]        commit_areg,
    input  logic [COMMIT_WIDTH-1:0][PW-1:0]        commit_preg,
    input  logic                                   flush,
    output logic                                   ready
);

`ifdef RAT_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    typedef enum logic {
        NORMAL  = 1'b0,
        RECOVER = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [PW-1:0] spec_tbl [NUM_AREGS];
    logic [PW-1:0] ret_tbl  [NUM_AREGS];
    logic [PW-1:0] spec_next [NUM_AREGS];
    logic [PW-1:0] ret_next  [NUM_AREGS];

    function automatic logic is_zero(input logic [AW-1:0] areg);
        return ZERO_REG && (areg == '0);
    endfunction

    assign ready = !rst && (state == NORMAL) && !flush;

    always_comb begin
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            for (int s = 0; s < 2; s++) begin
                rd_preg[i][s] = spec_tbl[rd_areg[i][s]];
                if (is_zero(rd_areg[i][s])) begin
                    rd_preg[i][s] = '0;
                end
            end
        end
    end

    // Older slots in the same group shadow the table value for younger slots.
    always_comb begin
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            old_preg[i] = spec_tbl[wr_areg[i]];
            for (int j = 0; j < i; j++) begin
                if (wr_en[j] && (wr_areg[j] == wr_areg[i])) begin
                    old_preg[i] = wr_preg[j];
                end
            end
            if (is_zero(wr_areg[i])) begin
                old_preg[i] = '0;
            end
        end
    end

    always_comb begin
        ret_next = ret_tbl;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (commit_en[k] && !is_zero(commit_areg[k])) begin
                ret_next[commit_areg[k]] = commit_preg[k];
            end
        end
    end

    // Recovery copies the retirement map with this cycle's commits already folded in.
    always_comb begin
        spec_next = spec_tbl;
        if (flush) begin
            spec_next = ret_next;
        end else if (state == NORMAL) begin
            for (int i = 0; i < RENAME_WIDTH; i++) begin
                if (wr_en[i] && !is_zero(wr_areg[i])) begin
                    spec_next[wr_areg[i]] = wr_preg[i];
                end
            end
        end
    end

    always_comb begin
        state_next = NORMAL;
        if (flush) begin
            state_next = RECOVER;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= NORMAL;
            for (int a = 0; a < NUM_AREGS; a++) begin
                spec_tbl[a] <= PW'(a);
                ret_tbl[a]  <= PW'(a);
            end
        end else begin
            state    <= state_next;
            spec_tbl <= spec_next;
            ret_tbl  <= ret_next;
        end
    end

endmodule

// File: tb/tb_register_alias_table.sv
// Testbench for register_alias_table: directed scenarios then randomized traffic
// checked against an array-based reference model of the alias tables.
module tb_register_alias_table;

    localparam int RW = 2;
    localparam int CW = 2;
    localparam int NA = 32;
    localparam int AW = 5;
    localparam int PW = 6;

    logic                         clk;
    logic                         rst;
    logic [RW-1:0][1:0][AW-1:0]   rd_areg;
    logic [RW-1:0][1:0][PW-1:0]   rd_preg;
    logic [RW-1:0]                wr_en;
    logic [RW-1:0][AW-1:0]        wr_areg;
    logic [RW-1:0][PW-1:0]        wr_preg;
    logic [RW-1:0][PW-1:0]        old_preg;
    logic [CW-1:0]                commit_en;
    logic [CW-1:0][AW-1:0]        commit_areg;
    logic [CW-1:0][PW-1:0]        commit_preg;
    logic                         flush;
    logic                         ready;

    int  pass_count;
    int  check_count;
    int  mspec [NA];
    int  mret  [NA];
    bit  mrecover;

`ifdef RAT_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    register_alias_table dut (
        .clk         (clk),
        .rst         (rst),
        .rd_areg     (rd_areg),
        .rd_preg     (rd_preg),
        .wr_en       (wr_en),
        .wr_areg     (wr_areg),
        .wr_preg     (wr_preg),
        .old_preg    (old_preg),
        .commit_en   (commit_en),
        .commit_areg (commit_areg),
        .commit_preg (commit_preg),
        .flush       (flush),
        .ready       (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit zero_areg(input int a);
        return ZERO_REG && (a == 0);
    endfunction

    function automatic int exp_rd(input int a);
        return zero_areg(a) ? 0 : mspec[a];
    endfunction

    function automatic int exp_old(input int i);
        int v;
        if (zero_areg(int'(wr_areg[i]))) return 0;
        v = mspec[wr_areg[i]];
        for (int j = 0; j < i; j++) begin
            if (wr_en[j] && wr_areg[j] == wr_areg[i]) v = int'(wr_preg[j]);
        end
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    endtask

    task automatic clearInputs();
        rst         = 1'b0;
        flush       = 1'b0;
        rd_areg     = '0;
        wr_en       = '0;
        wr_areg     = '0;
        wr_preg     = '0;
        commit_en   = '0;
        commit_areg = '0;
        commit_preg = '0;
    endtask

    // Settle to the falling edge and compare every output against the model.
    task automatic applyStimulus();
        @(negedge clk);
        checkOutput("ready", 32'(ready), 32'(!rst && !mrecover && !flush));
        if (!rst) begin
            for (int i = 0; i < RW; i++) begin
                for (int s = 0; s < 2; s++) begin
                    checkOutput($sformatf("rd_preg_%0d_%0d", i, s), 32'(rd_preg[i][s]),
                                32'(exp_rd(int'(rd_areg[i][s]))));
                end
                if (wr_en[i]) begin
                    checkOutput($sformatf("old_preg_%0d", i), 32'(old_preg[i]), 32'(exp_old(i)));
                end
            end
        end
    endtask

    task automatic advanceClock();
        @(posedge clk);
        if (rst) begin
            for (int a = 0; a < NA; a++) begin
                mspec[a] = a;
                mret[a]  = a;
            end
            mrecover = 1'b0;
        end else begin
            for (int k = 0; k < CW; k++) begin
                if (commit_en[k] && !zero_areg(int'(commit_areg[k])))
                    mret[commit_areg[k]] = int'(commit_preg[k]);
            end
            if (flush) begin
                mspec    = mret;
                mrecover = 1'b1;
            end else begin
                if (!mrecover) begin
                    for (int i = 0; i < RW; i++) begin
                        if (wr_en[i] && !zero_areg(int'(wr_areg[i])))
                            mspec[wr_areg[i]] = int'(wr_preg[i]);
                    end
                end
                mrecover = 1'b0;
            end
        end
        #1;
    endtask

    function automatic logic [AW-1:0] rand_areg();
        return ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, NA - 1));
    endfunction

    task automatic randomizeInputs();
        rst   = ($urandom_range(0, 63) == 0);
        flush = ($urandom_range(0, 9) == 0);
        for (int i = 0; i < RW; i++) begin
            wr_en[i]   = 1'($urandom_range(0, 1));
            wr_areg[i] = rand_areg();
            wr_preg[i] = PW'($urandom_range(0, 63));
            for (int s = 0; s < 2; s++) rd_areg[i][s] = rand_areg();
        end
        for (int k = 0; k < CW; k++) begin
            commit_en[k]   = 1'($urandom_range(0, 1));
            commit_areg[k] = rand_areg();
            commit_preg[k] = PW'($urandom_range(0, 63));
        end
    endtask

    initial begin
        pass_count  = 0;
        check_count = 0;
        mrecover    = 1'b0;
        for (int a = 0; a < NA; a++) begin
            mspec[a] = a;
            mret[a]  = a;
        end
        clearInputs();
        rst = 1'b1;
        applyStimulus();
        advanceClock();

        // Identity map after reset
        clearInputs();
        rd_areg[0][0] = 5'd5;
        rd_areg[0][1] = 5'd31;
        applyStimulus();
        checkOutput("t1_ready", 32'(ready), 32'd1);
        checkOutput("t1_rd5", 32'(rd_preg[0][0]), 32'd5);
        checkOutput("t1_rd31", 32'(rd_preg[0][1]), 32'd31);
        advanceClock();

        clearInputs();
        wr_en[0] = 1'b1; wr_areg[0] = 5'd3; wr_preg[0] = 6'd40;
        applyStimulus();
        checkOutput("t2_old", 32'(old_preg[0]), 32'd3);
        advanceClock();
        clearInputs();
        rd_areg[0][0] = 5'd3;
        applyStimulus();
        checkOutput("t2_rd3", 32'(rd_preg[0][0]), 32'd40);
        advanceClock();

        // Intra-group same-areg writes
        clearInputs();
        wr_en = 2'b11;
        wr_areg[0] = 5'd7; wr_preg[0] = 6'd41;
        wr_areg[1] = 5'd7; wr_preg[1] = 6'd42;
        applyStimulus();
        checkOutput("t3_old0", 32'(old_preg[0]), 32'd7);
        checkOutput("t3_old1", 32'(old_preg[1]), 32'd41);
        advanceClock();
        clearInputs();
        rd_areg[1][1] = 5'd7;
        applyStimulus();
        checkOutput("t3_rd7", 32'(rd_preg[1][1]), 32'd42);
        advanceClock();

        // Commit, speculative overwrite, then flush recovery
        clearInputs();
        commit_en[0] = 1'b1; commit_areg[0] = 5'd3; commit_preg[0] = 6'd40;
        applyStimulus();
        advanceClock();
        clearInputs();
        wr_en[0] = 1'b1; wr_areg[0] = 5'd3; wr_preg[0] = 6'd50;
        applyStimulus();
        advanceClock();
        clearInputs();
        flush = 1'b1;
        applyStimulus();
        checkOutput("t4_ready_flush", 32'(ready), 32'd0);
        advanceClock();
        clearInputs();
        wr_en[0] = 1'b1; wr_areg[0] = 5'd3; wr_preg[0] = 6'd55;
        applyStimulus();
        checkOutput("t4_ready_recover", 32'(ready), 32'd0);
        advanceClock();
        clearInputs();
        rd_areg[0][0] = 5'd3;
        applyStimulus();
        checkOutput("t4_ready_after", 32'(ready), 32'd1);
        checkOutput("t4_rd3", 32'(rd_preg[0][0]), 32'd40);
        advanceClock();

        // Flush merges same-cycle commit and drops same-cycle write
        clearInputs();
        flush = 1'b1;
        commit_en[1] = 1'b1; commit_areg[1] = 5'd9; commit_preg[1] = 6'd60;
        wr_en[0] = 1'b1; wr_areg[0] = 5'd9; wr_preg[0] = 6'd61;
        applyStimulus();
        advanceClock();
        clearInputs();
        applyStimulus();
        advanceClock();
        clearInputs();
        rd_areg[0][1] = 5'd9;
        applyStimulus();
        checkOutput("t5_rd9", 32'(rd_preg[0][1]), 32'd60);
        advanceClock();

        // Areg 0 handling
        clearInputs();
        wr_en[0] = 1'b1; wr_areg[0] = 5'd0; wr_preg[0] = 6'd45;
        applyStimulus();
        checkOutput("t6_old0", 32'(old_preg[0]), 32'd0);
        advanceClock();
        clearInputs();
        rd_areg[0][0] = 5'd0;
        applyStimulus();
        checkOutput("t6_rd0", 32'(rd_preg[0][0]), ZERO_REG ? 32'd0 : 32'd45);
        advanceClock();

        // Reset in the middle of RECOVER
        clearInputs();
        flush = 1'b1;
        applyStimulus();
        advanceClock();
        clearInputs();
        rst = 1'b1;
        applyStimulus();
        advanceClock();
        clearInputs();
        rd_areg[0][0] = 5'd3;
        rd_areg[1][0] = 5'd9;
        applyStimulus();
        checkOutput("t7_ready", 32'(ready), 32'd1);
        checkOutput("t7_rd3", 32'(rd_preg[0][0]), 32'd3);
        checkOutput("t7_rd9", 32'(rd_preg[1][0]), 32'd9);
        advanceClock();

        for (int c = 0; c < 600; c++) begin
            randomizeInputs();
            applyStimulus();
            advanceClock();
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
